theft_alarm_controller: RTL

Sequencing FSM and seconds timer for the anti-theft system. It drives the 2-bit `interval` selector into the time-parameter store and consumes the returned 4-bit `selected_time`. It counts the chosen delay in whole seconds, then arms, triggers, sounds and disarms the alarm from ignition and door inputs. It sits between the vehicle sensor inputs and the siren/status-LED outputs.

---
 rtl/anti_theft_pkg.sv | 27 ++
 rtl/seconds_timer.sv | 72 +++++++
 rtl/theft_alarm_controller.sv | 120 ++++++++++++
 3 files changed

// File: rtl/anti_theft_pkg.sv
// Shared types and constants for the anti-theft alarm controller and its seconds timer.
package anti_theft_pkg;

    localparam int unsigned TIME_W = 4;

    localparam logic [1:0] ARM_DELAY       = 2'd0;
    localparam logic [1:0] DRIVER_DELAY    = 2'd1;
    localparam logic [1:0] PASSENGER_DELAY = 2'd2;
    localparam logic [1:0] ALARM_ON        = 2'd3;

    typedef enum logic [2:0] {
        StArmed,
        StTriggered,
        StAlarm,
        StAlarmHold,
        StDisarmed,
        StWaitDoorOpen,
        StWaitDoorClose,
        StArming
    } state_e;

    // States whose exit is governed by the seconds timer.
    function automatic logic is_timed(input state_e s);
        return (s == StTriggered) || (s == StArming) || (s == StAlarmHold);
    endfunction

endpackage

// File: rtl/seconds_timer.sv
// Whole-second down-counter: loads a seconds value on start and pulses done once it has elapsed.
module seconds_timer
    import anti_theft_pkg::*;
#(
    parameter int unsigned CLKS_PER_SEC = 50_000_000
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic              cancel,
    input  logic [TIME_W-1:0] load_val,
    output logic              done
);

    localparam int unsigned   PW        = $clog2(CLKS_PER_SEC);
    localparam logic [PW-1:0] PRESC_MAX = PW'(CLKS_PER_SEC - 1);

    logic [PW-1:0]     presc_q, presc_d;
    logic [TIME_W-1:0] count_q, count_d;
    logic              active_q, active_d;
    logic              done_q, done_d;

    always_comb begin
        presc_d  = presc_q;
        count_d  = count_q;
        active_d = active_q;
        done_d   = 1'b0;
        if (cancel) begin
            // Cancel wins over a start arriving in the same cycle.
            active_d = 1'b0;
            presc_d  = '0;
            count_d  = '0;
        end else if (start) begin
            active_d = 1'b1;
            presc_d  = '0;
            count_d  = load_val;
        end else if (active_q) begin
            if (count_q == '0) begin
                done_d   = 1'b1;
                active_d = 1'b0;
            end else if (presc_q == PRESC_MAX) begin
                presc_d = '0;
                if (count_q == TIME_W'(1)) begin
                    done_d   = 1'b1;
                    active_d = 1'b0;
                    count_d  = '0;
                end else begin
                    count_d = count_q - TIME_W'(1);
                end
            end else begin
                presc_d = presc_q + PW'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            presc_q  <= '0;
            count_q  <= '0;
            active_q <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            presc_q  <= presc_d;
            count_q  <= count_d;
            active_q <= active_d;
            done_q   <= done_d;
        end
    end

    assign done = done_q;

endmodule

// File: rtl/theft_alarm_controller.sv
// Anti-theft sequencing FSM: arms, triggers, sounds and disarms the siren from ignition and doors,
// timing each phase with a parameter-store delay counted in whole seconds.
module theft_alarm_controller
    import anti_theft_pkg::*;
#(
    parameter int unsigned CLKS_PER_SEC = 50_000_000
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              ignition,
    input  logic              driver_door,
    input  logic              passenger_door,
    input  logic              reprogram,
    input  logic [TIME_W-1:0] selected_time,
    output logic [1:0]        interval,
    output logic              siren,
    output logic              status_led
);

    localparam int unsigned   PW        = $clog2(CLKS_PER_SEC);
    localparam logic [PW-1:0] BLINK_MAX = PW'(CLKS_PER_SEC - 1);

    state_e        state_q, state_d;
    logic [1:0]    interval_q, interval_d, trig_sel;
    logic          siren_q, siren_d;
    logic          led_q, led_d;
    logic [PW-1:0] blink_q, blink_d;
    logic          start_q, start_d;
    logic          cancel, timer_done, any_door;

    assign any_door = driver_door || passenger_door;

    always_comb begin
        state_d  = state_q;
        trig_sel = DRIVER_DELAY;
        case (state_q)
            StArmed: begin
                if (driver_door) begin
                    state_d = StTriggered;
                end else if (passenger_door) begin
                    state_d  = StTriggered;
                    trig_sel = PASSENGER_DELAY;
                end
            end
            StTriggered:     if (timer_done) state_d = StAlarm;
            StAlarm:         if (!any_door) state_d = StAlarmHold;
            StAlarmHold:     if (any_door) state_d = StAlarm;
                             else if (timer_done) state_d = StArmed;
            StDisarmed:      if (!ignition) state_d = StWaitDoorOpen;
            StWaitDoorOpen:  if (driver_door) state_d = StWaitDoorClose;
            StWaitDoorClose: if (!driver_door) state_d = StArming;
            StArming:        if (any_door) state_d = StWaitDoorClose;
                             else if (timer_done) state_d = StArmed;
            default:         state_d = StArmed;
        endcase
        if (reprogram) state_d = StArmed;
        if (ignition)  state_d = StDisarmed;

        // Combinational cancel kills the timer on the very edge that leaves a timed state.
        cancel  = (state_d != state_q) && is_timed(state_q);
        start_d = (state_d != state_q) && is_timed(state_d);

        case (state_d)
            StTriggered:          interval_d = (state_q == StTriggered) ? interval_q : trig_sel;
            StAlarm, StAlarmHold: interval_d = ALARM_ON;
            default:              interval_d = ARM_DELAY;
        endcase

        siren_d = (state_d == StAlarm) || (state_d == StAlarmHold);

        blink_d = '0;
        led_d   = 1'b0;
        if (state_d == StArmed) begin
            if (state_q == StArmed) begin
                if (blink_q == BLINK_MAX) begin
                    led_d = ~led_q;
                end else begin
                    blink_d = blink_q + PW'(1);
                    led_d   = led_q;
                end
            end
        end else begin
            led_d = (state_d == StTriggered) || siren_d;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= StArmed;
            interval_q <= ARM_DELAY;
            siren_q    <= 1'b0;
            led_q      <= 1'b0;
            blink_q    <= '0;
            start_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            interval_q <= interval_d;
            siren_q    <= siren_d;
            led_q      <= led_d;
            blink_q    <= blink_d;
            start_q    <= start_d;
        end
    end

    seconds_timer #(
        .CLKS_PER_SEC(CLKS_PER_SEC)
    ) u_timer (
        .clk     (clk),
        .rst_n   (rst_n),
        .start   (start_q),
        .cancel  (cancel),
        .load_val(selected_time),
        .done    (timer_done)
    );

    assign interval   = interval_q;
    assign siren      = siren_q;
    assign status_led = led_q;

endmodule
